// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter fed by a small byte FIFO over a valid/ready handshake.
// Bytes are popped straight into the shift register so back-to-back frames leave no idle gap.
module uart_tx_buffered #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 4,
   parameter int CNT_W        = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic             UART_tx,
   output logic             busy,
   output logic [CNT_W-1:0] fifo_count
);

   localparam int          PTR_W   = $clog2(FIFO_DEPTH);
   localparam logic [19:0] BAUD_TC = 20'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [19:0]       r_baud;
   logic [19:0]       w_baud_next;
   logic [2:0]        r_bit;
   logic [2:0]        w_bit_next;
   logic [7:0]        r_shift;
   logic [7:0]        w_shift_next;
   logic              r_tx;
   logic              w_tx_next;

   logic [7:0]        r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;

   logic              w_push;
   logic              w_pop;
   logic              w_nonempty;
   logic              w_tc;

   assign w_nonempty = (r_count != '0);
   assign w_tc       = (r_baud == BAUD_TC);
   assign tx_ready   = (r_count < CNT_W'(FIFO_DEPTH));
   assign w_push     = tx_valid & tx_ready;

   assign UART_tx    = r_tx;
   assign busy       = (r_state != S_IDLE);
   assign fifo_count = r_count;

   // Storage has no reset; only the pointers and count define occupancy.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= tx_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
      end else begin
         r_state <= w_state_next;
         r_baud  <= w_baud_next;
         r_bit   <= w_bit_next;
         r_shift <= w_shift_next;
         r_tx    <= w_tx_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_baud_next  = w_tc ? '0 : r_baud + 20'd1;
      w_bit_next   = r_bit;
      w_shift_next = r_shift;
      w_pop        = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_baud_next = '0;
            if (w_nonempty) begin
               w_pop        = 1'b1;
               w_shift_next = r_mem[r_rd_ptr];
               w_state_next = S_START;
            end
         end
         S_START: begin
            if (w_tc) begin
               w_state_next = S_DATA;
               w_bit_next   = '0;
            end
         end
         S_DATA: begin
            if (w_tc) begin
               w_shift_next = {1'b0, r_shift[7:1]};
               if (r_bit == 3'd7) begin
                  w_state_next = S_STOP;
               end else begin
                  w_bit_next = r_bit + 3'd1;
               end
            end
         end
         S_STOP: begin
            // A queued byte goes straight into a new start bit with no idle bit between frames.
            if (w_tc) begin
               if (w_nonempty) begin
                  w_pop        = 1'b1;
                  w_shift_next = r_mem[r_rd_ptr];
                  w_state_next = S_START;
               end else begin
                  w_state_next = S_IDLE;
               end
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase

      // Line level is registered from the next state so it changes on the same edge as the state.
      case (w_state_next)
         S_START: w_tx_next = 1'b0;
         S_DATA:  w_tx_next = w_shift_next[0];
         default: w_tx_next = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: pushes are logged into an expected queue, and a line monitor
// decodes every frame on UART_tx and compares it in order; a second instance uses default timing.
`timescale 1ns/1ps
module tb_uart_tx_buffered;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int CW    = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [7:0]    tx_data = 8'h00;
   logic          tx_valid = 1'b0;
   logic          tx_ready;
   logic          UART_tx;
   logic          busy;
   logic [CW-1:0] fifo_count;

   logic [7:0]    tx_data_d = 8'h00;
   logic          tx_valid_d = 1'b0;
   logic          tx_ready_d;
   logic          UART_tx_d;
   logic          busy_d;
   logic [2:0]    fifo_count_d;

   int            checks = 0;
   int            errors = 0;
   byte unsigned  exp_q[$];
   logic          mon_en = 1'b0;
   logic          mon_prev = 1'b1;
   logic [9:0]    mon_bits;
   int            mon_glitch;
   logic          mon_s;

   always #5 clk = ~clk;

   uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .UART_tx(UART_tx), .busy(busy), .fifo_count(fifo_count)
   );

   uart_tx_buffered dut_def (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data_d), .tx_valid(tx_valid_d),
      .tx_ready(tx_ready_d), .UART_tx(UART_tx_d), .busy(busy_d), .fifo_count(fifo_count_d)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // Called at a negedge; returns at the negedge following the transfer edge.
   task automatic push(input byte unsigned b);
      int w;
      w = 0;
      tx_data  = b;
      tx_valid = 1'b1;
      while (!tx_ready && w < 2000) begin
         @(negedge clk);
         w++;
      end
      if (!tx_ready) begin
         checks++;
         errors++;
         $display("FAIL push_timeout: tx_ready stuck at 0, required 1 for byte 0x%0h", b);
      end else begin
         exp_q.push_back(b);
      end
      @(negedge clk);
      $display("push 0x%02h count=%0d", b, fifo_count);
   endtask

   task automatic drain(input string name);
      int w;
      w = 0;
      tx_valid = 1'b0;
      while ((exp_q.size() != 0 || busy) && w < 3000) begin
         @(negedge clk);
         w++;
      end
      check({name, "_queue_empty"}, exp_q.size(), 0);
      check({name, "_idle"}, busy, 1'b0);
   endtask

   // Line monitor: every cycle of each bit must hold one level; byte order must match pushes.
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en && mon_prev && !UART_tx) begin
            mon_glitch = 0;
            for (int b = 0; b < 10; b++) begin
               for (int c = 0; c < CPB; c++) begin
                  if (b != 0 || c != 0) @(negedge clk);
                  mon_s = UART_tx;
                  if (c == 0) mon_bits[b] = mon_s;
                  else if (mon_s !== mon_bits[b]) mon_glitch++;
               end
            end
            check("frame_start_bit", mon_bits[0], 1'b0);
            check("frame_stop_bit", mon_bits[9], 1'b1);
            check("frame_bit_stable", mon_glitch, 0);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_frame: got 0x%02h, required no frame", mon_bits[8:1]);
            end else begin
               check("frame_data", mon_bits[8:1], exp_q.pop_front());
            end
            $display("frame 0x%02h", mon_bits[8:1]);
            mon_prev = mon_bits[9];
         end else begin
            mon_prev = UART_tx;
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int w;
      int bad;
      logic [9:0] frame;

      // Reset state while held and after release
      repeat (3) @(negedge clk);
      check("rst_hold_tx", UART_tx, 1'b1);
      check("rst_hold_busy", busy, 1'b0);
      check("rst_hold_ready", tx_ready, 1'b1);
      check("rst_hold_count", fifo_count, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_rel_tx", UART_tx, 1'b1);
      check("rst_rel_busy", busy, 1'b0);
      check("rst_rel_ready", tx_ready, 1'b1);
      check("rst_rel_count", fifo_count, 0);

      // Asynchronous reset in the middle of data bit 1 of 0xA5 (a 0 bit)
      push(8'hA5);
      push(8'h11);
      tx_valid = 1'b0;
      repeat (9) @(negedge clk);
      check("pre_rst_line", UART_tx, 1'b0);
      check("pre_rst_count", fifo_count, 1);
      check("pre_rst_busy", busy, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_tx", UART_tx, 1'b1);
      check("midrst_busy", busy, 1'b0);
      check("midrst_count", fifo_count, 0);
      check("midrst_ready", tx_ready, 1'b1);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      mon_en = 1'b1;

      // Single byte: latency and frame length
      push(8'hA5);
      check("single_count_after_push", fifo_count, 1);
      check("single_line_before_pop", UART_tx, 1'b1);
      check("single_busy_before_pop", busy, 1'b0);
      tx_valid = 1'b0;
      @(negedge clk);
      check("single_start_low", UART_tx, 1'b0);
      check("single_busy_rise", busy, 1'b1);
      check("single_count_after_pop", fifo_count, 0);
      repeat (39) @(negedge clk);
      check("single_busy_last_stop", busy, 1'b1);
      check("single_line_stop", UART_tx, 1'b1);
      @(negedge clk);
      check("single_busy_fall", busy, 1'b0);
      drain("single");

      // Back-to-back frames with no gap
      push(8'h00);
      push(8'hFF);
      push(8'h55);
      tx_valid = 1'b0;
      k = 1;
      while (busy && k < 500) begin
         k++;
         @(negedge clk);
      end
      check("b2b_busy_cycles", k, 120);
      drain("b2b");

      // Full FIFO with tx_valid held
      push(8'h01);
      push(8'h02);
      push(8'h03);
      push(8'h04);
      push(8'h05);
      check("full_count", fifo_count, 4);
      check("full_ready", tx_ready, 1'b0);
      check("full_busy", busy, 1'b1);
      tx_data  = 8'h06;
      tx_valid = 1'b1;
      repeat (20) @(negedge clk);
      check("full_hold_count", fifo_count, 4);
      check("full_hold_ready", tx_ready, 1'b0);
      push(8'h06);
      tx_valid = 1'b0;
      check("refill_count", fifo_count, 4);
      drain("full");

      // Push on the same edge as the STOP-to-START pop
      push(8'hA0);
      push(8'hB0);
      tx_valid = 1'b0;
      repeat (39) @(negedge clk);
      check("simul_pre_count", fifo_count, 1);
      check("simul_pre_line", UART_tx, 1'b1);
      push(8'hC0);
      tx_valid = 1'b0;
      check("simul_count", fifo_count, 1);
      check("simul_start", UART_tx, 1'b0);
      check("simul_busy", busy, 1'b1);
      drain("simul");

      // Default timing instance: 0x3C, every bit exactly 868 cycles
      frame = {1'b1, 8'h3C, 1'b0};
      @(negedge clk);
      check("def_ready", tx_ready_d, 1'b1);
      tx_data_d  = 8'h3C;
      tx_valid_d = 1'b1;
      @(negedge clk);
      tx_valid_d = 1'b0;
      check("def_line_before_pop", UART_tx_d, 1'b1);
      w = 0;
      while (UART_tx_d && w < 10) begin
         @(negedge clk);
         w++;
      end
      check("def_start_latency", w, 1);
      for (int b = 0; b < 10; b++) begin
         bad = 0;
         for (int c = 0; c < 868; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (UART_tx_d !== frame[b]) bad++;
         end
         check($sformatf("def_bit%0d_wrong_cycles", b), bad, 0);
         $display("def bit %0d level %0b", b, frame[b]);
      end
      check("def_busy_last_cycle", busy_d, 1'b1);
      @(negedge clk);
      check("def_busy_fall", busy_d, 1'b0);
      check("def_line_idle", UART_tx_d, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
